// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches one ROM word per cycle into a DEPTH-entry ring, head shown one cycle after push.
// Backpressure: fetch stalls (fetch_pc holds) while full and LE is low; flush restarts fetch at target_add.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        R,
   input  logic        LE,
   input  logic        flush,
   input  logic [7:0]  target_add,
   output logic [7:0]  rom_address,
   input  logic [31:0] rom_instruction,
   output logic [31:0] instruction,
   output logic [7:0]  pc_plus_4,
   output logic        valid,
   output logic [3:0]  count
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [7:0]  pc4;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [7:0]      fetch_pc;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [3:0]      count_q;
   logic            pop;
   logic            push;
   entry_t          head;

   assign valid = (count_q != 4'd0);
   assign pop   = LE & valid;
   assign push  = ~flush & ((count_q < 4'(DEPTH)) | pop);

   always_ff @(posedge clk) begin
      if (R) begin
         fetch_pc <= 8'd0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= 4'd0;
      end else if (flush) begin
         fetch_pc <= target_add;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= 4'd0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + 8'd4;
            wr_ptr   <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count_q <= count_q + 4'(push) - 4'(pop);
      end
   end

   // Storage is never reset; the head outputs are masked by valid instead.
   always_ff @(posedge clk) begin
      if (!R && push) begin
         mem[wr_ptr] <= '{instr: rom_instruction, pc4: fetch_pc + 8'd4};
      end
   end

   assign head        = mem[rd_ptr];
   assign rom_address = fetch_pc;
   assign count       = count_q;
   assign instruction = valid ? head.instr : 32'd0;
   assign pc_plus_4   = valid ? head.pc4   : 8'd0;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; legal values 2, 4, 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 R  input  1  reset, synchronous, active-high.
REQ-004 LE  input  1  consumer (IF/ID) load enable; 1 = consumer takes head entry this cycle.
REQ-005 flush  input  1  taken-branch indication from condition handler.
REQ-006 target_add  input  8  branch target byte address, valid when flush=1.
REQ-007 rom_address  output  8  instruction ROM address, combinational from fetch PC.
REQ-008 rom_instruction  input  32  ROM read data, combinational response to rom_address.
REQ-009 instruction  output  32  head entry instruction.
REQ-010 pc_plus_4  output  8  head entry fetch address + 4.
REQ-011 valid  output  1  head entry present.
REQ-012 count  output  4  number of occupied entries, 0..DEPTH.

Function
REQ-013 Internal state: fetch_pc (8 b), circular buffer of DEPTH entries {instr 32 b, pc4 8 b}, read pointer, write pointer, occupancy counter.
REQ-014 rom_address SHALL equal fetch_pc at all times.
REQ-015 valid SHALL be 1 iff count != 0.
REQ-016 When valid=1, instruction/pc_plus_4 SHALL show head entry; when valid=0, both SHALL be 0 (NOP bubble).
REQ-017 pop = LE & valid; LE with valid=0 SHALL have no effect.
REQ-018 push = ~flush & (count < DEPTH | pop); push writes {rom_instruction, fetch_pc+4} at write pointer, advances write pointer, fetch_pc <= fetch_pc + 4.
REQ-019 Simultaneous push and pop when full SHALL be permitted; count unchanged.
REQ-020 count next = count + push - pop when flush=0.
REQ-021 fetch_pc + 4 and pointer increments SHALL wrap modulo 256 and modulo DEPTH respectively, no saturation.
REQ-022 flush=1 SHALL, on the same edge, clear count and both pointers to 0, set fetch_pc <= target_add, perform no push and no pop; flush overrides LE.
REQ-023 First entry after flush SHALL be fetched from target_add on the following edge; valid rises one cycle after flush edge.
REQ-024 Latency: instruction at fetch_pc reaches head output one cycle after its push edge when queue was empty.
REQ-025 Full with LE=0: no push, fetch_pc holds, rom_address stable.
REQ-026 Entries SHALL emerge in strict fetch order; no entry duplicated or dropped absent flush.

Reset
REQ-027 R=1 at a rising edge SHALL set fetch_pc=0, count=0, pointers=0; outputs then instruction=0, pc_plus_4=0, valid=0, rom_address=0.
REQ-028 R SHALL take priority over flush, LE and push; mid-operation reset discards all entries.
REQ-029 Entry storage contents need not be cleared by reset; outputs are masked by valid.
REQ-030 First push after reset SHALL occur on the first edge with R=0, from address 0.

Verification
REQ-031 Reset, LE=0, ROM[0]=0xE3A01005, ROM[4]=0xE2811001: after 4 edges count=4, valid=1, instruction=0xE3A01005, pc_plus_4=4, rom_address=16; further edges no change.
REQ-032 Full queue, LE=1 continuously: one pop and one push per edge, count stays 4, heads sequence pc_plus_4 = 4,8,12,16,20...
REQ-033 fetch_pc=0x20, count=3, flush=1, target_add=0x40, LE=1: next cycle count=0, valid=0, instruction=0, rom_address=0x40; following edge valid=1, pc_plus_4=0x44.
REQ-034 fetch_pc=0xFC, space available: push gives pc_plus_4=0x00, next rom_address=0x00 (wrap).
REQ-035 Queue with 2 entries, R=1 with flush=1 and LE=1 same edge: count=0, rom_address=0, not target_add.
REQ-036 Alternating LE 1/0 from empty after reset: count never exceeds DEPTH, valid never drops once set, order of pc_plus_4 strictly ascending by 4.
